// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter and its ID FIFO.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_GNT = 1'b1
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int MAX_OUTSTANDING = 8;
  localparam int CNT_W           = 4;
  localparam int PTR_W           = 3;

endpackage

// File: rtl/dmem_port_arbiter_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered memory transactions.
module arb_id_fifo
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [MAX_OUTSTANDING-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_id = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester req/gnt/rvalid data-memory arbiter with zero-latency pass-through.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req_i,
  input  logic [31:0]      p0_addr_i,
  input  logic             p0_we_i,
  input  logic [3:0]       p0_be_i,
  input  logic [31:0]      p0_wdata_i,
  output logic             p0_gnt_o,
  output logic             p0_rvalid_o,
  output logic [31:0]      p0_rdata_o,
  input  logic             p1_req_i,
  input  logic [31:0]      p1_addr_i,
  input  logic             p1_we_i,
  input  logic [3:0]       p1_be_i,
  input  logic [31:0]      p1_wdata_i,
  output logic             p1_gnt_o,
  output logic             p1_rvalid_o,
  output logic [31:0]      p1_rdata_o,
  output logic             m_req_o,
  output logic [31:0]      m_addr_o,
  output logic             m_we_o,
  output logic [3:0]       m_be_o,
  output logic [31:0]      m_wdata_o,
  input  logic             m_gnt_i,
  input  logic             m_rvalid_i,
  input  logic [31:0]      m_rdata_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             rsp_err_o
);

  arb_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic             sel_c;
  logic             pick;
  logic             rsp_err_q, rsp_err_d;
  logic             fifo_full, fifo_empty, fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop, can_issue, any_req;

  assign any_req   = p0_req_i | p1_req_i;
  assign pop       = m_rvalid_i & ~fifo_empty & ~reset;
  // A response freeing a slot this cycle lets a new request through while full.
  assign can_issue = ~fifo_full | pop;
  assign push      = m_req_o & m_gnt_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;

  assign pick = (p0_req_i & p1_req_i) ? prio_q : p1_req_i;

  always_comb begin
    prio_d = prio_q;
    if (push) begin
      prio_d = ~sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= PORT0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign pick = p0_req_i ? PORT0 : PORT1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= PORT0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rsp_err_d = rsp_err_q | (m_rvalid_i & fifo_empty);
    case (state_q)
      S_IDLE: begin
        if (m_req_o && !m_gnt_i) begin
          state_d = S_WAIT_GNT;
          sel_d   = sel_c;
        end
      end
      S_WAIT_GNT: begin
        if (m_gnt_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_req_o = 1'b0;
    sel_c   = sel_q;
    if (!reset) begin
      if (state_q == S_WAIT_GNT) begin
        m_req_o = 1'b1;
      end else if (any_req && can_issue) begin
        m_req_o = 1'b1;
        sel_c   = pick;
      end
    end
  end

  assign m_addr_o  = m_req_o ? ((sel_c == PORT1) ? p1_addr_i  : p0_addr_i)  : '0;
  assign m_we_o    = m_req_o ? ((sel_c == PORT1) ? p1_we_i    : p0_we_i)    : 1'b0;
  assign m_be_o    = m_req_o ? ((sel_c == PORT1) ? p1_be_i    : p0_be_i)    : '0;
  assign m_wdata_o = m_req_o ? ((sel_c == PORT1) ? p1_wdata_i : p0_wdata_i) : '0;

  assign p0_gnt_o = push & (sel_c == PORT0);
  assign p1_gnt_o = push & (sel_c == PORT1);

  assign p0_rvalid_o = pop & (fifo_head == PORT0);
  assign p1_rvalid_o = pop & (fifo_head == PORT1);
  assign p0_rdata_o  = m_rdata_i;
  assign p1_rdata_o  = m_rdata_i;

  assign outstanding_o = fifo_count;
  assign rsp_err_o     = rsp_err_q;

  arb_id_fifo #(
    .DEPTH (OUTSTANDING_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (sel_c),
    .pop     (pop),
    .head_id (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: queue-based reference model checked every cycle plus literal spot checks.
module tb_dmem_port_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
  logic [3:0]  p0_be_i, p1_be_i;
  logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [3:0]  m_be_o;
  logic [3:0]  outstanding_o;
  logic        rsp_err_o;

  dmem_port_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
    .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
    .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .outstanding_o(outstanding_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: IDs of accepted transactions in order, a pending (locked) selection,
  // the last granted port and the sticky error flag.
  int mq[$];
  bit lock_v    = 1'b0;
  bit lock_port = 1'b0;
  bit last_gnt  = 1'b1;
  bit err_m     = 1'b0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic bit model_pick();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (p0_req_i && p1_req_i) return !last_gnt;
`endif
    return p0_req_i ? 1'b0 : 1'b1;
  endfunction

  function automatic void model_eval(output bit mreq, output bit sel, output bit pop);
    pop  = m_rvalid_i && (mq.size() > 0) && !reset;
    mreq = 1'b0;
    sel  = 1'b0;
    if (reset) return;
    if (lock_v) begin
      mreq = 1'b1;
      sel  = lock_port;
    end else if ((p0_req_i || p1_req_i) && (mq.size() < DEPTH || pop)) begin
      mreq = 1'b1;
      sel  = model_pick();
    end
  endfunction

  // Inputs change only just after posedge, so values seen here are those the next edge samples.
  always @(negedge clk) begin
    bit mreq, sel, pop, head, was_empty;
    model_eval(mreq, sel, pop);
    head = (mq.size() > 0) ? mq[0][0] : 1'b0;
    chk1 ("m_req",    m_req_o,   mreq);
    chk32("m_addr",   m_addr_o,  mreq ? (sel ? p1_addr_i : p0_addr_i) : 32'd0);
    chk1 ("m_we",     m_we_o,    mreq ? (sel ? p1_we_i : p0_we_i) : 1'b0);
    chk32("m_be",     {28'd0, m_be_o}, mreq ? {28'd0, (sel ? p1_be_i : p0_be_i)} : 32'd0);
    chk32("m_wdata",  m_wdata_o, mreq ? (sel ? p1_wdata_i : p0_wdata_i) : 32'd0);
    chk1 ("p0_gnt",   p0_gnt_o,  mreq && m_gnt_i && !sel);
    chk1 ("p1_gnt",   p1_gnt_o,  mreq && m_gnt_i && sel);
    chk1 ("p0_rvalid", p0_rvalid_o, pop && !head);
    chk1 ("p1_rvalid", p1_rvalid_o, pop && head);
    if (pop) begin
      chk32("p0_rdata", p0_rdata_o, m_rdata_i);
      chk32("p1_rdata", p1_rdata_o, m_rdata_i);
    end
    chk32("outstanding", {28'd0, outstanding_o}, 32'(mq.size()));
    chk1 ("rsp_err",  rsp_err_o, err_m);

    if (reset) begin
      mq.delete();
      lock_v   = 1'b0;
      last_gnt = 1'b1;
      err_m    = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      if (pop) void'(mq.pop_front());
      if (mreq && m_gnt_i) begin
        mq.push_back(int'(sel));
        lock_v   = 1'b0;
        last_gnt = sel;
      end else if (mreq) begin
        lock_v    = 1'b1;
        lock_port = sel;
      end
      if (m_rvalid_i && was_empty) err_m = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req_i = 0; p0_addr_i = 0; p0_we_i = 0; p0_be_i = 0; p0_wdata_i = 0;
    p1_req_i = 0; p1_addr_i = 0; p1_we_i = 0; p1_be_i = 0; p1_wdata_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0;
  endtask

  initial begin
    bit first;
    idle();
    reset = 1'b1;
    p0_req_i = 1'b1;
    m_gnt_i  = 1'b1;
    @(negedge clk);
    chk1("rst_m_req", m_req_o, 1'b0);
    chk1("rst_p0_gnt", p0_gnt_o, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk32("rst_outstanding", {28'd0, outstanding_o}, 32'd0);
    chk1("rst_err", rsp_err_o, 1'b0);

    // Single load: grant same cycle, response next cycle
    tick(); idle();
    p0_req_i = 1; p0_addr_i = 32'h2800; p0_be_i = 4'hF; m_gnt_i = 1;
    @(negedge clk);
    chk1("s1_p0_gnt", p0_gnt_o, 1'b1);
    chk32("s1_addr", m_addr_o, 32'h2800);
    tick(); idle();
    m_rvalid_i = 1; m_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk1("s1_p0_rvalid", p0_rvalid_o, 1'b1);
    chk32("s1_rdata", p0_rdata_o, 32'hDEADBEEF);
    chk1("s1_p1_rvalid", p1_rvalid_o, 1'b0);

    // Contention with gnt always high
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    tick(); idle();
    p0_req_i = 1; p0_addr_i = 32'h100; p1_req_i = 1; p1_addr_i = 32'h200; m_gnt_i = 1;
    @(negedge clk);
    chk1("s2_first_p0_gnt", p0_gnt_o, !first);
    chk1("s2_first_p1_gnt", p1_gnt_o, first);
    chk32("s2_first_addr", m_addr_o, first ? 32'h200 : 32'h100);
    tick();
    if (first) p1_req_i = 0; else p0_req_i = 0;
    @(negedge clk);
    chk1("s2_second_p0_gnt", p0_gnt_o, first);
    chk1("s2_second_p1_gnt", p1_gnt_o, !first);
    tick(); idle();
    m_rvalid_i = 1; m_rdata_i = 32'hA1;
    @(negedge clk);
    chk1("s2_rsp1_p0", p0_rvalid_o, !first);
    chk32("s2_outstanding", {28'd0, outstanding_o}, 32'd2);
    tick();
    m_rdata_i = 32'hA2;
    @(negedge clk);
    chk1("s2_rsp2_p0", p0_rvalid_o, first);

    // Stalled store: payload held while gnt is low, late p0 request waits
    tick(); idle();
    p1_req_i = 1; p1_addr_i = 32'h2600; p1_we_i = 1; p1_be_i = 4'b0011; p1_wdata_i = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin p0_req_i = 1; p0_addr_i = 32'h3000; end
      if (c == 3) m_gnt_i = 1;
      @(negedge clk);
      chk32("s3_addr", m_addr_o, 32'h2600);
      chk1("s3_we", m_we_o, 1'b1);
      chk32("s3_be", {28'd0, m_be_o}, 32'd3);
      chk32("s3_wdata", m_wdata_o, 32'h1234);
      chk1("s3_p0_gnt", p0_gnt_o, 1'b0);
      chk1("s3_p1_gnt", p1_gnt_o, c == 3);
      tick();
    end
    p1_req_i = 0;
    @(negedge clk);
    chk1("s3_p0_late_gnt", p0_gnt_o, 1'b1);
    chk32("s3_p0_late_addr", m_addr_o, 32'h3000);
    tick(); idle();
    m_rvalid_i = 1;
    @(negedge clk);
    chk1("s3_rsp_p1", p1_rvalid_o, 1'b1);
    tick();
    @(negedge clk);
    chk1("s3_rsp_p0", p0_rvalid_o, 1'b1);

    // Full FIFO blocks, same-cycle response lets the third request through
    tick(); idle();
    p0_req_i = 1; p0_addr_i = 32'h10; m_gnt_i = 1;
    @(negedge clk);
    chk1("s4_g1", p0_gnt_o, 1'b1);
    tick();
    p0_addr_i = 32'h14;
    @(negedge clk);
    chk1("s4_g2", p0_gnt_o, 1'b1);
    tick();
    p0_addr_i = 32'h18;
    @(negedge clk);
    chk1("s4_full_m_req", m_req_o, 1'b0);
    chk32("s4_full_outstanding", {28'd0, outstanding_o}, 32'd2);
    chk1("s4_full_gnt", p0_gnt_o, 1'b0);
    tick();
    m_rvalid_i = 1; m_rdata_i = 32'h55;
    @(negedge clk);
    chk1("s4_pass_m_req", m_req_o, 1'b1);
    chk1("s4_pass_gnt", p0_gnt_o, 1'b1);
    chk1("s4_pass_rvalid", p0_rvalid_o, 1'b1);
    chk32("s4_pass_addr", m_addr_o, 32'h18);
    tick(); idle();
    @(negedge clk);
    chk32("s4_after_outstanding", {28'd0, outstanding_o}, 32'd2);
    tick(); m_rvalid_i = 1;
    @(negedge clk);
    tick();
    @(negedge clk);

    // Ordered responses, then a stray response
    tick(); idle();
    p0_req_i = 1; p0_addr_i = 32'h40; m_gnt_i = 1;
    @(negedge clk);
    tick();
    p0_req_i = 0; p1_req_i = 1; p1_addr_i = 32'h44;
    @(negedge clk);
    chk1("s5_g2_p1", p1_gnt_o, 1'b1);
    tick();
    p1_req_i = 0; p0_req_i = 1; p0_addr_i = 32'h48; m_rvalid_i = 1;
    @(negedge clk);
    chk1("s5_g3_p0", p0_gnt_o, 1'b1);
    chk1("s5_r1_p0", p0_rvalid_o, 1'b1);
    tick();
    p0_req_i = 0;
    @(negedge clk);
    chk1("s5_r2_p1", p1_rvalid_o, 1'b1);
    tick();
    @(negedge clk);
    chk1("s5_r3_p0", p0_rvalid_o, 1'b1);
    tick();
    @(negedge clk);
    chk1("s5_stray_p0", p0_rvalid_o, 1'b0);
    chk1("s5_stray_p1", p1_rvalid_o, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk1("s5_err_set", rsp_err_o, 1'b1);
    tick(); reset = 1;
    @(negedge clk);
    tick(); reset = 0;
    @(negedge clk);
    chk1("s5_err_cleared", rsp_err_o, 1'b0);

    // Reset with a transaction outstanding; its late response is stray
    tick(); idle();
    p0_req_i = 1; p0_addr_i = 32'h80; m_gnt_i = 1;
    @(negedge clk);
    chk1("s6_gnt", p0_gnt_o, 1'b1);
    tick(); idle(); reset = 1;
    @(negedge clk);
    tick(); reset = 0; m_rvalid_i = 1;
    @(negedge clk);
    chk1("s6_late_rvalid", p0_rvalid_o, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk1("s6_err", rsp_err_o, 1'b1);
    chk32("s6_outstanding", {28'd0, outstanding_o}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING_DEPTH, default 2, max accepted-but-unanswered transactions (1..8).
REQ-002 SHALL have ports clk input 1 (sole clock) and reset input 1 (synchronous, active-high).
REQ-003 SHALL have, for each requester n in {0,1}: pn_req_i in 1 request; pn_addr_i in 32 byte address; pn_we_i in 1 write; pn_be_i in 4 byte enables; pn_wdata_i in 32 write data.
REQ-004 SHALL have, for each n: pn_gnt_o out 1 request accepted; pn_rvalid_o out 1 response valid; pn_rdata_o out 32 read data.
REQ-005 SHALL have memory-side ports m_req_o out 1, m_addr_o out 32, m_we_o out 1, m_be_o out 4, m_wdata_o out 32, m_gnt_i in 1, m_rvalid_i in 1, m_rdata_i in 32.
REQ-006 SHALL have status ports outstanding_o out 4 (unanswered count) and rsp_err_o out 1 (sticky unexpected-response flag).

Function
REQ-007 Protocol on both sides SHALL be req/gnt/rvalid: request accepted in the cycle req&gnt are high; exactly one rvalid per accepted request, at least one cycle later, in order.
REQ-008 Requesters SHALL hold req and payload stable until gnt; the arbiter relies on this and performs no payload registering.
REQ-009 FSM states SHALL be S_IDLE (no pending selection) and S_WAIT_GNT (selected port locked, m_req_o high, m_gnt_i low).
REQ-010 In S_IDLE with any pn_req_i high and outstanding_o < OUTSTANDING_DEPTH, arbitration SHALL select a port combinationally, drive m_req_o=1 and that port's payload onto m_*; m_gnt_i=1 keeps S_IDLE, else go to S_WAIT_GNT.
REQ-011 In S_WAIT_GNT the selection SHALL not change; m_gnt_i=1 returns to S_IDLE.
REQ-012 pn_gnt_o SHALL equal m_gnt_i & m_req_o & (selected==n); the unselected port's gnt SHALL be 0.
REQ-013 When m_req_o=0, m_addr_o/m_we_o/m_be_o/m_wdata_o SHALL be 0.
REQ-014 On each accepted request the selected port ID SHALL be pushed into an in-order ID FIFO of depth OUTSTANDING_DEPTH.
REQ-015 On m_rvalid_i with FIFO non-empty, pn_rvalid_o SHALL assert same cycle only for n == FIFO head, head popped; pn_rdata_o SHALL equal m_rdata_i for both ports (qualified by rvalid).
REQ-016 Full: when outstanding_o == OUTSTANDING_DEPTH, m_req_o SHALL stay 0 in S_IDLE unless m_rvalid_i frees a slot in the same cycle (pop-before-push permitted combinationally).
REQ-017 Simultaneous push and pop SHALL leave outstanding_o unchanged; FIFO pointers wrap modulo OUTSTANDING_DEPTH.
REQ-018 m_rvalid_i with FIFO empty SHALL be ignored for routing (no pn_rvalid_o) and SHALL set rsp_err_o until reset.
REQ-019 Latency: arbiter adds zero cycles on request and response paths (combinational pass-through).

Reset
REQ-020 Synchronous reset SHALL force S_IDLE, FIFO empty, outstanding_o=0, rsp_err_o=0, round-robin pointer to port 0; all gnt/rvalid/m_req_o outputs 0 during reset.
REQ-021 Reset mid-transaction SHALL discard outstanding IDs; responses arriving after reset SHALL be treated per REQ-018.

Configuration
REQ-022 With macro DMEM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: on contention the port not granted last wins; pointer updates only on accepted requests.
REQ-023 Without DMEM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, port 0 highest.

Structure
REQ-024 Shared package SHALL hold FSM state encodings (S_IDLE=1'b0, S_WAIT_GNT=1'b1), port ID constants, and the OUTSTANDING_DEPTH limit.
REQ-025 The ID FIFO SHALL be a sub-module named arb_id_fifo (1-bit entries, push/pop/full/empty/count).

Verification
REQ-026 p0 load addr 0x2800, m_gnt_i same cycle, m_rvalid_i next cycle rdata 0xDEADBEEF -> p0_gnt_o=1 cycle 0, p0_rvalid_o=1 with 0xDEADBEEF cycle 1, p1_rvalid_o=0.
REQ-027 p0 and p1 request same cycle, gnt always high -> fixed: p0 then p1; round-robin build with last grant p0: p1 first.
REQ-028 p1 store addr 0x2600 be 4'b0011 wdata 0x1234, m_gnt_i low 3 cycles -> m_* stable 4 cycles, p0 request arriving in cycle 1 not selected until p1 granted.
REQ-029 Depth 2: two grants with no rvalid, third request -> m_req_o=0, outstanding_o=2; rvalid in same cycle as third request -> third forwarded, outstanding_o stays 2.
REQ-030 Grants p0,p1,p0 then three rvalids -> rvalid order p0,p1,p0; extra m_rvalid_i -> rsp_err_o=1, no pn_rvalid_o; reset clears rsp_err_o.
